// File: rtl/axis_fifo_reader_pkg.sv
// Shared constants and types for the AXI-Stream FIFO reader: skid buffer depth,
// occupancy and pointer types, and the occupancy update rule.
package axis_fifo_reader_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef logic [1:0]                      occ_t;
    typedef logic [$clog2(BUF_DEPTH)-1:0]    ptr_t;

    function automatic occ_t occ_next(input occ_t occ, input logic capture, input logic pop);
        return occ + occ_t'(capture) - occ_t'(pop);
    endfunction

endpackage

// File: rtl/axis_fifo_reader_if.sv
// FIFO read port plus AXI-Stream master bundle; master is the reader side,
// slave is the FIFO/stream sink side.
interface axis_fifo_reader_if #(
    parameter int unsigned DLEN = 8
);

    logic            o_fifo_ren;
    logic [DLEN-1:0] i_fifo_rdata;
    logic            i_fifo_rempty;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DLEN-1:0] m_axis_tdata;

    modport master (
        output o_fifo_ren,
        input  i_fifo_rdata,
        input  i_fifo_rempty,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata
    );

    modport slave (
        input  o_fifo_ren,
        output i_fifo_rdata,
        output i_fifo_rempty,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata
    );

endinterface

// File: rtl/axis_fifo_reader.sv
// Converts a one-cycle-latency FIFO read port into an AXI-Stream master using
// a two-entry register buffer so tready never reaches tvalid/tdata combinationally.
module axis_fifo_reader
    import axis_fifo_reader_pkg::*;
#(
    parameter int unsigned DLEN = 8
) (
    input  logic               clk,
    input  logic               rstn,
    axis_fifo_reader_if.master bus
);

    logic [DLEN-1:0] buf_q [BUF_DEPTH];
    ptr_t            head_q;
    ptr_t            tail_q;
    occ_t            occ_q;
    logic            inflight_q;
    logic            run_q;

    logic            pop;
    logic            ren;
    logic [2:0]      demand;

    // A read is issued only if the word it returns is guaranteed a buffer slot,
    // counting the word already in flight and the slot freed by this cycle's pop.
    // run_q keeps reads off until the first edge after reset release.
    always_comb begin
        pop    = (occ_q != '0) && bus.m_axis_tready;
        demand = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        ren    = run_q && !bus.i_fifo_rempty && (demand < 3'(BUF_DEPTH));
    end

    assign bus.o_fifo_ren    = ren;
    assign bus.m_axis_tvalid = (occ_q != '0);
    assign bus.m_axis_tdata  = buf_q[head_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= ren;
            occ_q      <= occ_next(occ_q, inflight_q, pop);
            if (inflight_q) begin
                buf_q[tail_q] <= bus.i_fifo_rdata;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Bench for axis_fifo_reader: behavioural FIFO with one-cycle read latency,
// scoreboard of expected beats, and a negedge monitor that pops and compares.
module tb_axis_fifo_reader;

    localparam int unsigned DLEN = 8;

    logic clk = 1'b0;
    logic rstn;
    logic tready;

    axis_fifo_reader_if #(.DLEN(DLEN)) bus ();

    axis_fifo_reader #(.DLEN(DLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [DLEN-1:0] fifo_q [$];
    logic [DLEN-1:0] exp_q  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [DLEN-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // FIFO model: data one cycle after ren, empty flag registered.
    logic [DLEN-1:0] fifo_rdata  = '0;
    logic            fifo_rempty = 1'b1;
    logic [DLEN-1:0] fifo_word;

    always @(posedge clk) begin
        if (bus.o_fifo_ren && fifo_q.size() != 0) begin
            fifo_word = fifo_q.pop_front();
            fifo_rdata <= fifo_word;
        end
        fifo_rempty <= (fifo_q.size() == 0);
    end

    assign bus.i_fifo_rdata  = fifo_rdata;
    assign bus.i_fifo_rempty = fifo_rempty;
    assign bus.m_axis_tready = tready;

    // Monitor: inputs change at posedge+1, so negedge values are those the next edge uses.
    logic            stall_seen = 1'b0;
    logic [DLEN-1:0] stall_data = '0;
    logic [DLEN-1:0] exp_word;

    always @(negedge clk) begin
        if (!rstn) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_tvalid", 32'(bus.m_axis_tvalid), 1);
                check("stall_tdata", 32'(bus.m_axis_tdata), 32'(stall_data));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got 0x%0h, expected no beat at %0t",
                             bus.m_axis_tdata, $time);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("beat_data", 32'(bus.m_axis_tdata), 32'(exp_word));
                end
            end
            if (bus.o_fifo_ren) begin
                check("ren_while_empty", 32'(fifo_rempty), 0);
            end
            stall_seen = bus.m_axis_tvalid && !bus.m_axis_tready;
            stall_data = bus.m_axis_tdata;
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || bus.m_axis_tvalid) && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int beats;
        int rens;
        int n;
        int base;

        // Reset state with a non-empty FIFO, then first-word latency.
        rstn   = 1'b0;
        tready = 1'b1;
        #1;
        push(8'hA5);
        @(negedge clk);
        check("rst_ren", 32'(bus.o_fifo_ren), 0);
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
        check("rst_tdata", 32'(bus.m_axis_tdata), 0);
        #2 rstn = 1'b1;
        #1 check("ren_before_first_edge", 32'(bus.o_fifo_ren), 0);
        @(negedge clk);
        check("first_ren_N", 32'(bus.o_fifo_ren), 1);
        check("first_tvalid_N", 32'(bus.m_axis_tvalid), 0);
        @(negedge clk);
        check("first_ren_N1", 32'(bus.o_fifo_ren), 0);
        check("first_tvalid_N1", 32'(bus.m_axis_tvalid), 0);
        @(negedge clk);
        check("first_tvalid_N2", 32'(bus.m_axis_tvalid), 1);
        check("first_tdata_N2", 32'(bus.m_axis_tdata), 'hA5);
        @(negedge clk);
        check("first_tvalid_N3", 32'(bus.m_axis_tvalid), 0);

        // Streaming 0x01..0x10, then underflow boundary.
        drive_slot();
        for (int i = 1; i <= 16; i++) push(8'(i));
        n = 0;
        while (!bus.m_axis_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
            @(negedge clk);
        end
        check("stream_beats", 32'(beats), 16);
        check("underflow_tvalid", 32'(bus.m_axis_tvalid), 0);
        for (int i = 0; i < 4; i++) begin
            check("underflow_ren", 32'(bus.o_fifo_ren), 0);
            @(negedge clk);
        end
        drive_slot();
        push(8'h77);
        n = 0;
        while (!bus.o_fifo_ren && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("refill_ren", 32'(bus.o_fifo_ren), 1);
        drain("refill_drained", 20);

        // Backpressure: only two reads while stalled.
        drive_slot();
        tready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i));
        rens = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_fifo_ren) rens++;
        end
        check("bp_ren_pulses", 32'(rens), 2);
        check("bp_tvalid", 32'(bus.m_axis_tvalid), 1);
        check("bp_tdata", 32'(bus.m_axis_tdata), 'h01);
        drive_slot();
        tready = 1'b1;
        drain("bp_drained", 30);

        // Random 50% tready over 256 words.
        drive_slot();
        for (int i = 0; i < 256; i++) push(8'((i * 7 + 3) & 255));
        n = 0;
        while ((exp_q.size() != 0 || bus.m_axis_tvalid) && n < 3000) begin
            drive_slot();
            tready = 1'($urandom_range(0, 1));
            n++;
        end
        tready = 1'b1;
        check("random_drained", 32'(exp_q.size()), 0);

        // Reset mid-stream with the buffer full after three pops.
        drive_slot();
        tready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (6) @(negedge clk);
        drive_slot();
        tready = 1'b1;
        base = pops;
        n = 0;
        while (pops < base + 3 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        drive_slot();
        tready = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_tvalid", 32'(bus.m_axis_tvalid), 1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_tvalid", 32'(bus.m_axis_tvalid), 0);
        check("midrst_ren", 32'(bus.o_fifo_ren), 0);
        check("midrst_tdata", 32'(bus.m_axis_tdata), 0);
        exp_q = '{8'h06, 8'h07, 8'h08};
        tready = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_hold_ren", 32'(bus.o_fifo_ren), 0);
        #2 rstn = 1'b1;
        n = 0;
        while (!bus.m_axis_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_first", 32'(bus.m_axis_tdata), 'h06);
        drain("post_rst_drained", 30);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_fifo_reader.md
AXIS_FIFO_READER -- requirements
Module: axis_fifo_reader

Interface
REQ-001 SHALL have parameter DLEN, default 8, data width in bits, matching the FIFO data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port o_fifo_ren  output  1  FIFO read enable; one word consumed per cycle asserted.
REQ-005 SHALL have port i_fifo_rdata  input  DLEN  FIFO read data, valid exactly one cycle after o_fifo_ren.
REQ-006 SHALL have port i_fifo_rempty  input  1  FIFO empty flag.
REQ-007 SHALL have port m_axis_tvalid  output  1  AXI-Stream master valid.
REQ-008 SHALL have port m_axis_tready  input  1  AXI-Stream slave ready.
REQ-009 SHALL have port m_axis_tdata  output  DLEN  AXI-Stream master data.

Function
REQ-010 SHALL hold a 2-entry register buffer (head/tail pointers, occupancy occ 0..2) plus a 1-bit in-flight flag set for the cycle after o_fifo_ren.
REQ-011 SHALL define pop = m_axis_tvalid && m_axis_tready.
REQ-012 SHALL assert o_fifo_ren = !i_fifo_rempty && (occ + inflight - pop) < 2, evaluated combinationally.
REQ-013 SHALL never assert o_fifo_ren while i_fifo_rempty is high.
REQ-014 SHALL write i_fifo_rdata into the tail entry at the clock edge ending the cycle in which inflight is 1.
REQ-015 SHALL drive m_axis_tvalid = (occ != 0) and m_axis_tdata = head entry, both from registers only, with no combinational path from m_axis_tready.
REQ-016 SHALL hold m_axis_tdata stable and m_axis_tvalid high from assertion until a pop occurs.
REQ-017 SHALL deliver words in exactly FIFO read order with no loss or duplication.
REQ-018 SHALL give a first-word latency of 2 cycles: o_fifo_ren in cycle N, capture at end of N+1, m_axis_tvalid high in N+2.
REQ-019 SHALL sustain one word per cycle when the FIFO is non-empty and m_axis_tready is held high.
REQ-020 SHALL handle a capture and a pop in the same cycle: occ unchanged, head and tail both advance.
REQ-021 SHALL never overflow the buffer: occ + inflight <= 2 at every edge.
REQ-022 SHALL, with m_axis_tready low, fill to occ=2 and then hold o_fifo_ren low.

Reset
REQ-023 SHALL, while rstn is low, clear occ, inflight, head and tail to 0 and force m_axis_tvalid=0 and o_fifo_ren=0 regardless of i_fifo_rempty.
REQ-024 SHALL reset m_axis_tdata registers to 0.
REQ-025 SHALL, on reset mid-operation, discard buffered and in-flight words; the first word after reset is the next one read from the FIFO.
REQ-026 SHALL issue no o_fifo_ren before the first rising clk edge after rstn deasserts.

Structure
REQ-027 SHALL take the buffer depth constant (2) and the occupancy typedef (2 bits, 0..2) from the shared AXI-Stream FIFO package.
REQ-028 SHALL be implemented as a single module with no sub-module; the buffer is inline registers.
REQ-029 SHALL contain no RAM; it connects to the FIFO read port only.

Verification
REQ-030 SHALL cover first word: FIFO holds 0xA5, tready=1 -> ren in cycle N, tvalid=1 with tdata=0xA5 in N+2, tvalid=0 in N+3.
REQ-031 SHALL cover streaming: FIFO holds 0x01..0x10, tready=1 -> 16 consecutive beats 0x01..0x10 with no gap after the first.
REQ-032 SHALL cover backpressure: FIFO holds 0x01..0x04, tready=0 for 10 cycles -> exactly 2 ren pulses, tdata=0x01 stable, then tready=1 -> 0x01..0x04 in order.
REQ-033 SHALL cover random tready (50%) over 256 words -> scoreboard match, tvalid/tdata stable while stalled, never ren while empty.
REQ-034 SHALL cover reset mid-stream: assert rstn low after 3 of 0x01..0x08 popped while occ=2 -> tvalid=0 and ren=0 immediately, and after release the next beat equals the FIFO's next unread word.
REQ-035 SHALL cover underflow boundary: FIFO empties while tready=1 -> tvalid drops after the last word and ren stays low until rempty falls.
